// File: rtl/chat_sched_if.sv
// Key-event bundle for chat_sched: raw keys, filtered keys and the press-event
// valid/ack handshake. The design uses the master side; the consumer uses slave.
interface chat_sched_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]  in;
    logic          en;
    logic [N-1:0]  out;
    logic          evt_valid;
    logic [IW-1:0] evt_ch;
    logic          evt_ack;
    logic          busy;

    modport master (
        input  in, en, evt_ack,
        output out, evt_valid, evt_ch, busy
    );

    modport slave (
        output in, en, evt_ack,
        input  out, evt_valid, evt_ch, busy
    );
endinterface

// File: rtl/chat_sched.sv
// Shared chatter-blanking scheduler: one hold-off counter granted round-robin to N
// active-low keys. Define CHAT_SCHED_SYNC_EN to add a 2-flop input synchronizer.
module chat_sched #(
    parameter int unsigned N    = 4,
    parameter int unsigned HOLD = 15,
    parameter int unsigned CW   = 4
) (
    input logic          clk,
    input logic          rst,
    chat_sched_if.master bus
);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BLANK, ACKW} state_t;

    state_t        state_q, state_n;
    logic [N-1:0]  keys, prev_q, pend_q, pend_n, fall, gmask, req;
    logic [IW-1:0] ptr_q, ptr_n, grant_q, grant_n, ch_q, ch_n, sel, cand, ptr_wrap;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          valid_q, valid_n, busy_q, sel_found;
    int unsigned   j;

`ifdef CHAT_SCHED_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus.in;
            sync2_q <= sync1_q;
        end
    end

    assign keys = sync2_q;
`else
    assign keys = bus.in;
`endif

    // The channel owning the counter cannot re-request while its blanking/ack is open.
    always_comb begin
        gmask = '0;
        if (state_q != IDLE) gmask[grant_q] = 1'b1;
    end

    assign fall     = prev_q & ~keys;
    assign req      = (pend_q | fall) & ~gmask;
    assign ptr_wrap = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        j         = 0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j    = (32'(ptr_q) + k) % N;
            cand = IW'(j);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        pend_n  = pend_q | (fall & ~gmask);
        ptr_n   = ptr_q;
        grant_n = grant_q;
        ch_n    = ch_q;
        cnt_n   = cnt_q;
        valid_n = valid_q;

        if (valid_q && bus.evt_ack) valid_n = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en && sel_found) begin
                    state_n     = BLANK;
                    grant_n     = sel;
                    ch_n        = sel;
                    valid_n     = 1'b1;
                    cnt_n       = CW'(HOLD - 1);
                    pend_n[sel] = 1'b0;
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    if (valid_n) begin
                        state_n = ACKW;
                    end else begin
                        state_n = IDLE;
                        ptr_n   = ptr_wrap;
                    end
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            ACKW: begin
                if (bus.evt_ack) begin
                    state_n = IDLE;
                    ptr_n   = ptr_wrap;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '1;
            pend_q  <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            prev_q  <= keys;
            pend_q  <= pend_n;
            ptr_q   <= ptr_n;
            grant_q <= grant_n;
            ch_q    <= ch_n;
            cnt_q   <= cnt_n;
            valid_q <= valid_n;
            busy_q  <= (state_n != IDLE);
        end
    end

    // Filtered keys: only the granted channel is forced low, and only while blanking.
    always_comb begin
        bus.out = keys;
        if (state_q == BLANK) bus.out[grant_q] = 1'b0;
    end

    assign bus.evt_valid = valid_q;
    assign bus.evt_ch    = ch_q;
    assign bus.busy      = busy_q;
endmodule
